// File: rtl/apb_master_bridge.sv
// Command-to-APB master bridge: command FIFO feeding an IDLE/SETUP/ACCESS(/RD_CAP) sequencer.
// Define APB_MASTER_PREADY_EN to add the pready port and wait-state support (RD_CAP then unused).
module apb_master_bridge #(
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32,
   parameter int CMD_DEPTH = 4
) (
   input  logic              pclk,
   input  logic              rst_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_wdata,
   output logic              rsp_valid,
   output logic              rsp_write,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic [ADDR_W-1:0] paddr,
   output logic              pwrite,
   output logic              psel,
   output logic              penable,
   output logic [DATA_W-1:0] pwdata,
`ifdef APB_MASTER_PREADY_EN
   input  logic              pready,
`endif
   input  logic [DATA_W-1:0] prdata
);

   localparam int PTR_W = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
   localparam int CNT_W = $clog2(CMD_DEPTH + 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETUP,
      ST_ACCESS,
      ST_RD_CAP
   } state_t;

   state_t r_state;
   state_t w_next;

   logic              r_fifo_write [CMD_DEPTH];
   logic [ADDR_W-1:0] r_fifo_addr  [CMD_DEPTH];
   logic [DATA_W-1:0] r_fifo_wdata [CMD_DEPTH];
   logic [PTR_W-1:0]  r_wptr;
   logic [PTR_W-1:0]  r_rptr;
   logic [CNT_W-1:0]  r_count;

   logic              r_pwrite;
   logic [ADDR_W-1:0] r_paddr;
   logic [DATA_W-1:0] r_pwdata;
   logic              r_rsp_valid;
   logic              r_rsp_write;
   logic [DATA_W-1:0] r_rsp_rdata;

   logic w_push;
   logic w_pop;
   logic w_empty;
   logic w_done;

   // Readiness reflects fullness only, so a full FIFO refuses a push even when popping.
   assign cmd_ready = (r_count != CNT_W'(CMD_DEPTH));
   assign w_push    = cmd_valid && cmd_ready;
   assign w_empty   = (r_count == '0);
   assign w_pop     = !w_empty && ((r_state == ST_IDLE) || w_done);

   always_ff @(posedge pclk) begin
      if (w_push) begin
         r_fifo_write[r_wptr] <= cmd_write;
         r_fifo_addr[r_wptr]  <= cmd_addr;
         r_fifo_wdata[r_wptr] <= cmd_wdata;
      end
   end

   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + PTR_W'(1);
         if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      w_done = 1'b0;
      case (r_state)
         ST_IDLE:   if (!w_empty) w_next = ST_SETUP;
         ST_SETUP:  w_next = ST_ACCESS;
         ST_ACCESS: begin
`ifdef APB_MASTER_PREADY_EN
            if (pready) w_done = 1'b1;
`else
            if (r_pwrite) w_done = 1'b1;
            else          w_next = ST_RD_CAP;
`endif
         end
         ST_RD_CAP: w_done = 1'b1;
         default:   w_next = ST_IDLE;
      endcase
      if (w_done) w_next = w_empty ? ST_IDLE : ST_SETUP;
   end

   // Completion captures prdata in whichever state ends the read (ACCESS or RD_CAP).
   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         r_paddr     <= '0;
         r_pwrite    <= 1'b0;
         r_pwdata    <= '0;
         r_rsp_valid <= 1'b0;
         r_rsp_write <= 1'b0;
         r_rsp_rdata <= '0;
      end else begin
         r_rsp_valid <= w_done;
         if (w_done) begin
            r_rsp_write <= r_pwrite;
            r_rsp_rdata <= r_pwrite ? '0 : prdata;
         end
         if (w_pop) begin
            r_paddr  <= r_fifo_addr[r_rptr];
            r_pwrite <= r_fifo_write[r_rptr];
            r_pwdata <= r_fifo_wdata[r_rptr];
         end
      end
   end

   assign psel      = (r_state == ST_SETUP) || (r_state == ST_ACCESS);
   assign penable   = (r_state == ST_ACCESS);
   assign paddr     = r_paddr;
   assign pwrite    = r_pwrite;
   assign pwdata    = r_pwdata;
   assign rsp_valid = r_rsp_valid;
   assign rsp_write = r_rsp_write;
   assign rsp_rdata = r_rsp_rdata;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Bench for apb_master_bridge: directed vector table, hand sequences, and random traffic
// against a transaction-level model; an APB slave memory answers the bus.
module tb_apb_master_bridge;

   localparam int DEPTH = 4;

   typedef struct packed {
      logic        w;
      logic [31:0] a;
      logic [31:0] d;
   } cmd_t;

   typedef struct {
      bit          v;
      bit          w;
      logic [31:0] a;
      logic [31:0] d;
      bit          e_psel;
      bit          e_pen;
      logic [31:0] e_paddr;
      logic [31:0] e_pwdata;
      bit          e_rspv;
      bit          e_rspw;
      logic [31:0] e_rdata;
   } vec_t;

   logic        pclk = 1'b0;
   logic        rst_n;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_write;
   logic [31:0] cmd_addr;
   logic [31:0] cmd_wdata;
   logic        rsp_valid;
   logic        rsp_write;
   logic [31:0] rsp_rdata;
   logic [31:0] paddr;
   logic        pwrite;
   logic        psel;
   logic        penable;
   logic [31:0] pwdata;
   logic [31:0] prdata;
`ifdef APB_MASTER_PREADY_EN
   logic        pready;
`endif

   int n_pass  = 0;
   int n_total = 0;
   int n_rsp_dut = 0;
   int n_comp_model = 0;
   bit seen_full = 1'b0;

   apb_master_bridge #(.ADDR_W(32), .DATA_W(32), .CMD_DEPTH(DEPTH)) dut (
      .pclk(pclk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_write(rsp_write), .rsp_rdata(rsp_rdata),
      .paddr(paddr), .pwrite(pwrite), .psel(psel), .penable(penable), .pwdata(pwdata),
`ifdef APB_MASTER_PREADY_EN
      .pready(pready),
`endif
      .prdata(prdata)
   );

   always #5 pclk = ~pclk;

   // Slave memory, 16 words indexed by paddr[5:2].
   logic [31:0] s_mem [16] = '{default: '0};
`ifdef APB_MASTER_PREADY_EN
   logic [31:0] s_garb = '0;
   always @(posedge pclk) begin
      s_garb <= $urandom;
      if (psel && penable && pready && pwrite) s_mem[paddr[5:2]] <= pwdata;
   end
   assign prdata = (psel && penable && !pwrite) ? s_mem[paddr[5:2]] : s_garb;
`else
   // Zero-wait slave: prdata is registered on the ACCESS edge, garbage otherwise.
   always @(posedge pclk) begin
      if (psel && penable) begin
         if (pwrite) s_mem[paddr[5:2]] <= pwdata;
         else        prdata <= s_mem[paddr[5:2]];
      end else begin
         prdata <= $urandom;
      end
   end
`endif

   // Reference model: pending queue plus the active command and its bus-cycle position
   // (0 = setup, 1 = access, 2 = read capture); a response follows the last bus cycle.
   cmd_t        mq[$];
   bit          m_act;
   cmd_t        m_cur;
   int          m_pos;
   bit          m_rsp;
   logic [31:0] m_paddr, m_pwdata, m_rsp_rdata;
   logic        m_pwrite, m_rsp_write;
   logic [31:0] m_mem [16] = '{default: '0};

   function automatic int cmd_len(bit w);
`ifdef APB_MASTER_PREADY_EN
      return 2;
`else
      return w ? 2 : 3;
`endif
   endfunction

   function automatic void model_reset();
      mq.delete();
      m_act = 0; m_pos = 0; m_rsp = 0;
      m_paddr = '0; m_pwdata = '0; m_pwrite = 1'b0;
      m_rsp_write = 1'b0; m_rsp_rdata = '0;
   endfunction

   function automatic void model_step(bit v, cmd_t c, bit rdy_in);
      bit fin;
      bit rdy;
      int n_pre;
      rdy = rdy_in;
`ifndef APB_MASTER_PREADY_EN
      rdy = 1'b1;
`endif
      n_pre = mq.size();
      fin = m_act && (m_pos == cmd_len(m_cur.w) - 1) && (m_pos != 1 || rdy);
      m_rsp = fin;
      if (fin) begin
         n_comp_model++;
         m_rsp_write = m_cur.w;
         if (m_cur.w) begin
            m_mem[m_cur.a[5:2]] = m_cur.d;
            m_rsp_rdata = '0;
         end else begin
            m_rsp_rdata = m_mem[m_cur.a[5:2]];
         end
      end
      if ((!m_act || fin) && n_pre > 0) begin
         m_cur = mq.pop_front();
         m_act = 1; m_pos = 0;
         m_paddr = m_cur.a; m_pwrite = m_cur.w; m_pwdata = m_cur.d;
      end else if (fin) begin
         m_act = 0;
      end else if (m_act && !(m_pos == 1 && !rdy)) begin
         m_pos++;
      end
      if (v && n_pre < DEPTH) mq.push_back(c);
   endfunction

   function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endfunction

   function automatic void fail(string nm);
      n_total++;
      $display("FAIL %s: bound expired", nm);
   endfunction

   function automatic cmd_t mk(bit w, logic [31:0] a, logic [31:0] d);
      cmd_t c;
      c.w = w; c.a = a; c.d = d;
      return c;
   endfunction

   function automatic void check_model();
      chk("cmd_ready", 32'(cmd_ready), 32'(mq.size() < DEPTH));
      chk("psel",      32'(psel),      32'(m_act && m_pos < 2));
      chk("penable",   32'(penable),   32'(m_act && m_pos == 1));
      chk("paddr",     paddr,          m_paddr);
      chk("pwrite",    32'(pwrite),    32'(m_pwrite));
      chk("pwdata",    pwdata,         m_pwdata);
      chk("rsp_valid", 32'(rsp_valid), 32'(m_rsp));
      if (m_rsp) begin
         chk("rsp_write", 32'(rsp_write), 32'(m_rsp_write));
         chk("rsp_rdata", rsp_rdata,      m_rsp_rdata);
      end
      if (rsp_valid) n_rsp_dut++;
      if (!cmd_ready) seen_full = 1'b1;
   endfunction

   task automatic tick(input bit v, input cmd_t c, input bit rdy);
      cmd_valid = v; cmd_write = c.w; cmd_addr = c.a; cmd_wdata = c.d;
`ifdef APB_MASTER_PREADY_EN
      pready = rdy;
`endif
      if (rst_n) model_step(v, c, rdy);
      else       model_reset();
      @(posedge pclk);
      @(negedge pclk);
      check_model();
   endtask

   task automatic drain();
      bit idle;
      idle = 0;
      for (int i = 0; i < 80; i++) begin
         if (!m_act && mq.size() == 0 && !m_rsp) begin
            idle = 1;
            break;
         end
         tick(0, mk(0, '0, '0), 1);
      end
      if (!idle) fail("drain");
   endtask

   vec_t tbl [12];

   initial begin
      cmd_t c;
      bit acc;
      int cyc;
      logic [31:0] cap;
      logic [31:0] a_hold;

      tbl[0]  = '{1, 1, 32'h10, 32'hA5A5_0001, 0, 0, 32'h00, 32'h0000_0000, 0, 0, 32'h0};
      tbl[1]  = '{0, 0, 32'h00, 32'h0,        1, 0, 32'h10, 32'hA5A5_0001, 0, 0, 32'h0};
      tbl[2]  = '{0, 0, 32'h00, 32'h0,        1, 1, 32'h10, 32'hA5A5_0001, 0, 0, 32'h0};
      tbl[3]  = '{0, 0, 32'h00, 32'h0,        0, 0, 32'h10, 32'hA5A5_0001, 1, 1, 32'h0};
      tbl[4]  = '{1, 1, 32'h20, 32'h1234_5678, 0, 0, 32'h10, 32'hA5A5_0001, 0, 0, 32'h0};
      tbl[5]  = '{1, 0, 32'h20, 32'h0,        1, 0, 32'h20, 32'h1234_5678, 0, 0, 32'h0};
      tbl[6]  = '{0, 0, 32'h00, 32'h0,        1, 1, 32'h20, 32'h1234_5678, 0, 0, 32'h0};
      tbl[7]  = '{0, 0, 32'h00, 32'h0,        1, 0, 32'h20, 32'h0000_0000, 1, 1, 32'h0};
      tbl[8]  = '{0, 0, 32'h00, 32'h0,        1, 1, 32'h20, 32'h0000_0000, 0, 0, 32'h0};
      tbl[9]  = '{0, 0, 32'h00, 32'h0,        0, 0, 32'h20, 32'h0000_0000, 0, 0, 32'h0};
      tbl[10] = '{0, 0, 32'h00, 32'h0,        0, 0, 32'h20, 32'h0000_0000, 1, 0, 32'h1234_5678};
      tbl[11] = '{0, 0, 32'h00, 32'h0,        0, 0, 32'h20, 32'h0000_0000, 0, 0, 32'h0};

      rst_n = 1'b0;
      cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
`ifdef APB_MASTER_PREADY_EN
      pready = 1'b1;
`endif
      model_reset();
      repeat (3) @(negedge pclk);
      chk("rst_psel",      32'(psel),      32'd0);
      chk("rst_penable",   32'(penable),   32'd0);
      chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_paddr",     paddr,          32'd0);
      chk("rst_pwdata",    pwdata,         32'd0);
      chk("rst_rsp_rdata", rsp_rdata,      32'd0);
      chk("rst_pwrite",    32'(pwrite | rsp_write), 32'd0);
      rst_n = 1'b1;

`ifndef APB_MASTER_PREADY_EN
      for (int i = 0; i < 12; i++) begin
         tick(tbl[i].v, mk(tbl[i].w, tbl[i].a, tbl[i].d), 1);
         chk($sformatf("tbl%0d_psel", i),    32'(psel),      32'(tbl[i].e_psel));
         chk($sformatf("tbl%0d_penable", i), 32'(penable),   32'(tbl[i].e_pen));
         chk($sformatf("tbl%0d_paddr", i),   paddr,          tbl[i].e_paddr);
         chk($sformatf("tbl%0d_pwdata", i),  pwdata,         tbl[i].e_pwdata);
         chk($sformatf("tbl%0d_rsp_valid", i), 32'(rsp_valid), 32'(tbl[i].e_rspv));
         if (tbl[i].e_rspv) begin
            chk($sformatf("tbl%0d_rsp_write", i), 32'(rsp_write), 32'(tbl[i].e_rspw));
            chk($sformatf("tbl%0d_rsp_rdata", i), rsp_rdata,      tbl[i].e_rdata);
         end
      end
`else
      // Read held in ACCESS for three pready=0 cycles.
      tick(1, mk(1, 32'h30, 32'hCAFE_F00D), 1);
      drain();
      tick(1, mk(0, 32'h30, 32'h0), 1);
      tick(0, mk(0, '0, '0), 1);
      tick(0, mk(0, '0, '0), 0);
      a_hold = paddr;
      for (int i = 0; i < 3; i++) begin
         tick(0, mk(0, '0, '0), 0);
         chk("wait_paddr_stable", paddr, a_hold);
         chk("wait_penable", 32'(penable & psel), 32'd1);
         chk("wait_no_rsp", 32'(rsp_valid), 32'd0);
      end
      pready = 1'b1;
      cap = prdata;
      tick(0, mk(0, '0, '0), 1);
      chk("pready_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("pready_rdata", rsp_rdata, cap);
      drain();
`endif

      // Back-to-back writes held until accepted; fills the FIFO.
      cyc = 0;
      for (int k = 0; k < 10; k++) begin
         c = mk(1, 32'h100 + 32'(k * 4), $urandom);
         acc = 0;
         for (int t = 0; t < 24 && !acc; t++) begin
            acc = (mq.size() < DEPTH);
            tick(1, c, cyc >= 8);
            cyc++;
         end
         if (!acc) fail("push_accept");
      end
      drain();
      chk("fifo_full_seen", 32'(seen_full), 32'd1);

      // Reset during ACCESS of a 3-command burst.
      for (int k = 0; k < 3; k++) tick(1, mk(1, 32'h200 + 32'(k * 4), $urandom), 1);
      acc = 0;
      for (int t = 0; t < 10 && !acc; t++) begin
         if (m_act && m_pos == 1) acc = 1;
         else tick(0, mk(0, '0, '0), 1);
      end
      if (!acc) fail("reach_access");
      rst_n = 1'b0;
      #1;
      chk("arst_psel",    32'(psel),    32'd0);
      chk("arst_penable", 32'(penable), 32'd0);
      model_reset();
      tick(0, mk(0, '0, '0), 1);
      tick(0, mk(0, '0, '0), 1);
      rst_n = 1'b1;
      tick(1, mk(0, 32'h100, 32'h0), 1);
      drain();

      // Random mixed traffic.
      for (int i = 0; i < 400; i++) begin
         c = mk(1'($urandom_range(0, 1)), $urandom, $urandom);
         tick($urandom_range(0, 9) < 6, c, $urandom_range(0, 3) != 0);
      end
      drain();
      chk("rsp_count", 32'(n_rsp_dut), 32'(n_comp_model));

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
